// File: rtl/zynq_axil_fifo_bridge.sv
// rtl/zynq_axil_fifo_bridge.sv - AXI4-Lite slave bridging PS writes/reads to PS->PL / PL->PS word FIFOs and a CSR bank
// Optional loopback of PS->PL into PL->PS: define ZYNQ_AXIL_FIFO_BRIDGE_LOOPBACK_EN
module zynq_axil_fifo_bridge #(
    parameter int C_S00_AXI_DATA_WIDTH = 32,
    parameter int C_S00_AXI_ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH           = 16,
    parameter int NUM_CSR              = 4
) (
    input  logic                                    aclk,
    input  logic                                    aresetn,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]         s00_axi_awaddr,
    input  logic [2:0]                              s00_axi_awprot,
    input  logic                                    s00_axi_awvalid,
    output logic                                    s00_axi_awready,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]         s00_axi_wdata,
    input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]       s00_axi_wstrb,
    input  logic                                    s00_axi_wvalid,
    output logic                                    s00_axi_wready,
    output logic [1:0]                              s00_axi_bresp,
    output logic                                    s00_axi_bvalid,
    input  logic                                    s00_axi_bready,
    input  logic [C_S00_AXI_ADDR_WIDTH-1:0]         s00_axi_araddr,
    input  logic [2:0]                              s00_axi_arprot,
    input  logic                                    s00_axi_arvalid,
    output logic                                    s00_axi_arready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]         s00_axi_rdata,
    output logic [1:0]                              s00_axi_rresp,
    output logic                                    s00_axi_rvalid,
    input  logic                                    s00_axi_rready,
    output logic [C_S00_AXI_DATA_WIDTH-1:0]         ps_to_pl_data_o,
    output logic                                    ps_to_pl_v_o,
    input  logic                                    ps_to_pl_ready_i,
    input  logic [C_S00_AXI_DATA_WIDTH-1:0]         pl_to_ps_data_i,
    input  logic                                    pl_to_ps_v_i,
    output logic                                    pl_to_ps_ready_o,
    output logic [C_S00_AXI_DATA_WIDTH*NUM_CSR-1:0] csr_o
);
    localparam int DW = C_S00_AXI_DATA_WIDTH;
    localparam int WA = C_S00_AXI_ADDR_WIDTH - 2;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          r_bvalid, r_rvalid, r_ovf, r_unf;
    logic [1:0]    r_bresp, r_rresp;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_csr [NUM_CSR];
    logic [DW-1:0] r_a_mem [FIFO_DEPTH];
    logic [DW-1:0] r_b_mem [FIFO_DEPTH];
    logic [PW-1:0] r_a_wp, r_a_rp, r_b_wp, r_b_rp;
    logic [CW-1:0] r_a_cnt, r_b_cnt;

    logic          w_wr_hs, w_rd_hs, w_a_full, w_a_empty, w_b_full, w_b_empty;
    logic          w_a_push, w_a_pop, w_b_push, w_b_pop, w_ovf_set, w_unf_set, w_lb_rd;
    logic          w_wr_fifo, w_wr_stat, w_rd_fifo;
    logic [1:0]    w_rresp;
    logic [DW-1:0] w_rdata, w_a_head, w_b_head, w_b_din;
    logic [WA-1:0] w_waddr, w_raddr;
    logic          w_unused;

    function automatic logic is_csr_page(input logic [WA-1:0] a);
        return a[WA-1:6] == (WA-6)'(1);
    endfunction

    assign w_unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign w_waddr  = s00_axi_awaddr[C_S00_AXI_ADDR_WIDTH-1:2];
    assign w_raddr  = s00_axi_araddr[C_S00_AXI_ADDR_WIDTH-1:2];

    // Ready lines are combinational but gated by reset so they read 0 while held in reset
    assign w_wr_hs         = aresetn & s00_axi_awvalid & s00_axi_wvalid & ~r_bvalid;
    assign w_rd_hs         = aresetn & s00_axi_arvalid & ~r_rvalid;
    assign s00_axi_awready = w_wr_hs;
    assign s00_axi_wready  = w_wr_hs;
    assign s00_axi_arready = aresetn & ~r_rvalid;
    assign s00_axi_bvalid  = r_bvalid;
    assign s00_axi_bresp   = r_bresp;
    assign s00_axi_rvalid  = r_rvalid;
    assign s00_axi_rresp   = r_rresp;
    assign s00_axi_rdata   = r_rdata;

    assign w_a_full  = (r_a_cnt == CW'(FIFO_DEPTH));
    assign w_a_empty = (r_a_cnt == '0);
    assign w_b_full  = (r_b_cnt == CW'(FIFO_DEPTH));
    assign w_b_empty = (r_b_cnt == '0);
    assign w_a_head  = r_a_mem[r_a_rp];
    assign w_b_head  = r_b_mem[r_b_rp];
    assign ps_to_pl_data_o = w_a_head;

    assign w_wr_fifo = w_wr_hs & (w_waddr == WA'(0));
    assign w_wr_stat = w_wr_hs & (w_waddr == WA'(4));
    assign w_rd_fifo = w_rd_hs & (w_raddr == WA'(2));
    assign w_a_push  = w_wr_fifo & (~w_a_full | w_a_pop);
    assign w_ovf_set = w_wr_fifo & ~w_a_push;
    assign w_b_pop   = w_rd_fifo & ~w_b_empty;
    assign w_unf_set = w_rd_fifo & w_b_empty;

`ifdef ZYNQ_AXIL_FIFO_BRIDGE_LOOPBACK_EN
    logic r_lb;
    logic w_drain;
    assign w_drain          = r_lb & ~w_a_empty & ~w_b_full;
    assign w_a_pop          = r_lb ? w_drain : (~w_a_empty & ps_to_pl_ready_i);
    assign w_b_push         = r_lb ? w_drain : (pl_to_ps_v_i & ~w_b_full);
    assign w_b_din          = r_lb ? w_a_head : pl_to_ps_data_i;
    assign ps_to_pl_v_o     = ~w_a_empty & ~r_lb;
    assign pl_to_ps_ready_o = ~w_b_full & ~r_lb;
    assign w_lb_rd          = r_lb;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_lb <= 1'b0;
        end else if (w_wr_stat) begin
            r_lb <= s00_axi_wdata[8];
        end
    end
`else
    assign w_a_pop          = ~w_a_empty & ps_to_pl_ready_i;
    assign w_b_push         = pl_to_ps_v_i & ~w_b_full;
    assign w_b_din          = pl_to_ps_data_i;
    assign ps_to_pl_v_o     = ~w_a_empty;
    assign pl_to_ps_ready_o = ~w_b_full;
    assign w_lb_rd          = 1'b0;
`endif

    always_comb begin
        w_rdata = '0;
        w_rresp = RESP_OKAY;
        if (w_raddr == WA'(1)) begin
            w_rdata = DW'(CW'(FIFO_DEPTH) - r_a_cnt);
        end else if (w_raddr == WA'(2)) begin
            if (w_b_empty) w_rresp = RESP_SLVERR;
            else           w_rdata = w_b_head;
        end else if (w_raddr == WA'(3)) begin
            w_rdata = DW'(r_b_cnt);
        end else if (w_raddr == WA'(4)) begin
            w_rdata = DW'({w_lb_rd, 6'b0, r_unf, r_ovf});
        end else if (is_csr_page(w_raddr)) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                if (w_raddr[5:0] == 6'(i)) w_rdata = r_csr[i];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_bvalid <= 1'b0;
            r_bresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rresp  <= RESP_OKAY;
            r_rdata  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_ovf_set ? RESP_SLVERR : RESP_OKAY;
            end else if (s00_axi_bready) begin
                r_bvalid <= 1'b0;
            end
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rdata;
                r_rresp  <= w_rresp;
            end else if (s00_axi_rready) begin
                r_rvalid <= 1'b0;
            end
            // A new event in the same cycle as a W1C clear keeps the bit set
            r_ovf <= w_ovf_set | (r_ovf & ~(w_wr_stat & s00_axi_wdata[0]));
            r_unf <= w_unf_set | (r_unf & ~(w_wr_stat & s00_axi_wdata[1]));
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < NUM_CSR; i++) r_csr[i] <= '0;
        end else if (w_wr_hs && is_csr_page(w_waddr)) begin
            for (int i = 0; i < NUM_CSR; i++) begin
                if (w_waddr[5:0] == 6'(i)) begin
                    for (int b = 0; b < DW/8; b++) begin
                        if (s00_axi_wstrb[b]) r_csr[i][8*b +: 8] <= s00_axi_wdata[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CSR; g++) begin : g_csr_out
        assign csr_o[DW*g +: DW] = r_csr[g];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_a_wp  <= '0;
            r_a_rp  <= '0;
            r_a_cnt <= '0;
            r_b_wp  <= '0;
            r_b_rp  <= '0;
            r_b_cnt <= '0;
        end else begin
            if (w_a_push) r_a_wp <= r_a_wp + PW'(1);
            if (w_a_pop)  r_a_rp <= r_a_rp + PW'(1);
            if (w_a_push & ~w_a_pop)      r_a_cnt <= r_a_cnt + CW'(1);
            else if (~w_a_push & w_a_pop) r_a_cnt <= r_a_cnt - CW'(1);
            if (w_b_push) r_b_wp <= r_b_wp + PW'(1);
            if (w_b_pop)  r_b_rp <= r_b_rp + PW'(1);
            if (w_b_push & ~w_b_pop)      r_b_cnt <= r_b_cnt + CW'(1);
            else if (~w_b_push & w_b_pop) r_b_cnt <= r_b_cnt - CW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (w_a_push) r_a_mem[r_a_wp] <= s00_axi_wdata;
        if (w_b_push) r_b_mem[r_b_wp] <= w_b_din;
    end

endmodule

// File: tb/tb_zynq_axil_fifo_bridge.sv
// tb/tb_zynq_axil_fifo_bridge.sv - directed and randomized bench for zynq_axil_fifo_bridge against a queue model
`timescale 1ns/1ps
module tb_zynq_axil_fifo_bridge;
    localparam int D  = 16;
    localparam int NC = 4;

    logic         aclk = 1'b0;
    logic         aresetn = 1'b1;
    logic [9:0]   s00_axi_awaddr = '0, s00_axi_araddr = '0;
    logic [2:0]   s00_axi_awprot = '0, s00_axi_arprot = '0;
    logic         s00_axi_awvalid = 0, s00_axi_wvalid = 0, s00_axi_bready = 0;
    logic         s00_axi_arvalid = 0, s00_axi_rready = 0;
    logic [31:0]  s00_axi_wdata = '0;
    logic [3:0]   s00_axi_wstrb = '0;
    logic         s00_axi_awready, s00_axi_wready, s00_axi_bvalid, s00_axi_arready, s00_axi_rvalid;
    logic [1:0]   s00_axi_bresp, s00_axi_rresp;
    logic [31:0]  s00_axi_rdata, ps_to_pl_data_o;
    logic         ps_to_pl_v_o, pl_to_ps_ready_o;
    logic         ps_to_pl_ready_i = 0, pl_to_ps_v_i = 0;
    logic [31:0]  pl_to_ps_data_i = '0;
    logic [32*NC-1:0] csr_o;

    zynq_axil_fifo_bridge #(.C_S00_AXI_DATA_WIDTH(32), .C_S00_AXI_ADDR_WIDTH(10),
                            .FIFO_DEPTH(D), .NUM_CSR(NC)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s00_axi_awaddr(s00_axi_awaddr), .s00_axi_awprot(s00_axi_awprot),
        .s00_axi_awvalid(s00_axi_awvalid), .s00_axi_awready(s00_axi_awready),
        .s00_axi_wdata(s00_axi_wdata), .s00_axi_wstrb(s00_axi_wstrb),
        .s00_axi_wvalid(s00_axi_wvalid), .s00_axi_wready(s00_axi_wready),
        .s00_axi_bresp(s00_axi_bresp), .s00_axi_bvalid(s00_axi_bvalid), .s00_axi_bready(s00_axi_bready),
        .s00_axi_araddr(s00_axi_araddr), .s00_axi_arprot(s00_axi_arprot),
        .s00_axi_arvalid(s00_axi_arvalid), .s00_axi_arready(s00_axi_arready),
        .s00_axi_rdata(s00_axi_rdata), .s00_axi_rresp(s00_axi_rresp),
        .s00_axi_rvalid(s00_axi_rvalid), .s00_axi_rready(s00_axi_rready),
        .ps_to_pl_data_o(ps_to_pl_data_o), .ps_to_pl_v_o(ps_to_pl_v_o), .ps_to_pl_ready_i(ps_to_pl_ready_i),
        .pl_to_ps_data_i(pl_to_ps_data_i), .pl_to_ps_v_i(pl_to_ps_v_i), .pl_to_ps_ready_o(pl_to_ps_ready_o),
        .csr_o(csr_o)
    );

    always #5 aclk = ~aclk;

    int n_chk = 0;
    int n_err = 0;
    bit cmp_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: actual=%08h required=%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: FIFOs as queues, registers as plain variables
    logic [31:0] q_a[$];
    logic [31:0] q_b[$];
    logic [31:0] m_csr [NC];
    bit          m_ovf, m_unf, m_lb, m_bvalid, m_rvalid;
    logic [1:0]  m_bresp, m_rresp;
    logic [31:0] m_rdata;

    int          na, nb, wa, ra, ci;
    bit          wr_hs, rd_hs, a_pop, b_pl, a_push, ovf_set, unf_set, lb_n;
    logic [1:0]  clr;
    logic [31:0] hd;

    function automatic int csr_index(input int byte_addr);
        if (byte_addr >= 'h100 && byte_addr < 'h100 + 4*NC) return (byte_addr - 'h100) / 4;
        return -1;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            q_a.delete(); q_b.delete();
            for (int i = 0; i < NC; i++) m_csr[i] = '0;
            m_ovf = 0; m_unf = 0; m_lb = 0;
            m_bvalid = 0; m_bresp = 0; m_rvalid = 0; m_rresp = 0; m_rdata = 0;
        end else begin
            wr_hs = s00_axi_awvalid && s00_axi_wvalid && !m_bvalid;
            rd_hs = s00_axi_arvalid && !m_rvalid;
            na = q_a.size(); nb = q_b.size();
            a_pop = m_lb ? (na > 0 && nb < D) : (na > 0 && ps_to_pl_ready_i);
            b_pl  = !m_lb && pl_to_ps_v_i && nb < D;
            wa = int'(s00_axi_awaddr) & 'h3FC;
            ra = int'(s00_axi_araddr) & 'h3FC;
            ovf_set = 0; unf_set = 0; clr = 0; a_push = 0; lb_n = m_lb;
            if (rd_hs) begin
                m_rvalid = 1; m_rresp = 0; m_rdata = 0;
                ci = csr_index(ra);
                if (ra == 'h004) m_rdata = 32'(D - na);
                else if (ra == 'h008) begin
                    if (nb > 0) m_rdata = q_b.pop_front();
                    else begin m_rresp = 2; unf_set = 1; end
                end
                else if (ra == 'h00C) m_rdata = 32'(nb);
                else if (ra == 'h010) m_rdata = (32'(m_lb) << 8) | (32'(m_unf) << 1) | 32'(m_ovf);
                else if (ci >= 0) m_rdata = m_csr[ci];
            end else if (s00_axi_rready) m_rvalid = 0;
            if (wr_hs) begin
                m_bvalid = 1; m_bresp = 0;
                ci = csr_index(wa);
                if (wa == 'h000) begin
                    if (na < D || a_pop) a_push = 1;
                    else begin ovf_set = 1; m_bresp = 2; end
                end else if (wa == 'h010) begin
                    clr = s00_axi_wdata[1:0];
`ifdef ZYNQ_AXIL_FIFO_BRIDGE_LOOPBACK_EN
                    lb_n = s00_axi_wdata[8];
`endif
                end else if (ci >= 0) begin
                    for (int b = 0; b < 4; b++)
                        if (s00_axi_wstrb[b]) m_csr[ci][8*b +: 8] = s00_axi_wdata[8*b +: 8];
                end
            end else if (s00_axi_bready) m_bvalid = 0;
            if (a_pop) begin
                hd = q_a.pop_front();
                if (m_lb) q_b.push_back(hd);
            end
            if (b_pl) q_b.push_back(pl_to_ps_data_i);
            if (a_push) q_a.push_back(s00_axi_wdata);
            m_ovf = ovf_set || (m_ovf && !clr[0]);
            m_unf = unf_set || (m_unf && !clr[1]);
            m_lb = lb_n;
        end
    end

    always @(negedge aclk) begin
        if (cmp_en) begin
            chk("awready", 32'(s00_axi_awready), 32'(aresetn && s00_axi_awvalid && s00_axi_wvalid && !m_bvalid));
            chk("wready", 32'(s00_axi_wready), 32'(aresetn && s00_axi_awvalid && s00_axi_wvalid && !m_bvalid));
            chk("arready", 32'(s00_axi_arready), 32'(aresetn && !m_rvalid));
            chk("bvalid", 32'(s00_axi_bvalid), 32'(m_bvalid));
            chk("bresp", 32'(s00_axi_bresp), 32'(m_bresp));
            chk("rvalid", 32'(s00_axi_rvalid), 32'(m_rvalid));
            chk("rresp", 32'(s00_axi_rresp), 32'(m_rresp));
            chk("rdata", s00_axi_rdata, m_rdata);
            chk("ps_to_pl_v", 32'(ps_to_pl_v_o), 32'(!m_lb && q_a.size() > 0));
            if (!m_lb && q_a.size() > 0) chk("ps_to_pl_data", ps_to_pl_data_o, q_a[0]);
            chk("pl_to_ps_ready", 32'(pl_to_ps_ready_o), 32'(!m_lb && q_b.size() < D));
            for (int i = 0; i < NC; i++) chk("csr_o", csr_o[32*i +: 32], m_csr[i]);
        end
    end

    task automatic wr(input logic [9:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        bit hs = 0;
        bit got = 0;
        resp = 2'bxx;
        s00_axi_awaddr = a; s00_axi_wdata = d; s00_axi_wstrb = s;
        s00_axi_awvalid = 1; s00_axi_wvalid = 1; s00_axi_bready = 0;
        for (int i = 0; i < 32 && !hs; i++) begin
            @(negedge aclk); hs = s00_axi_awready && s00_axi_wready;
            @(posedge aclk); #1;
        end
        s00_axi_awvalid = 0; s00_axi_wvalid = 0; s00_axi_bready = 1;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge aclk);
            if (s00_axi_bvalid) begin got = 1; resp = s00_axi_bresp; end
            @(posedge aclk); #1;
        end
        s00_axi_bready = 0;
        if (!hs || !got) begin
            n_chk++; n_err++;
            $display("FAIL wr_timeout: handshake=%0b response=%0b required 1 1", hs, got);
        end
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        bit got = 0;
        d = 'x; resp = 2'bxx;
        s00_axi_araddr = a; s00_axi_arvalid = 1; s00_axi_rready = 0;
        for (int i = 0; i < 32 && !hs; i++) begin
            @(negedge aclk); hs = s00_axi_arready;
            @(posedge aclk); #1;
        end
        s00_axi_arvalid = 0; s00_axi_rready = 1;
        for (int i = 0; i < 32 && !got; i++) begin
            @(negedge aclk);
            if (s00_axi_rvalid) begin got = 1; d = s00_axi_rdata; resp = s00_axi_rresp; end
            @(posedge aclk); #1;
        end
        s00_axi_rready = 0;
        if (!hs || !got) begin
            n_chk++; n_err++;
            $display("FAIL rd_timeout: handshake=%0b response=%0b required 1 1", hs, got);
        end
    endtask

    logic [9:0] atab [12] = '{10'h000, 10'h004, 10'h008, 10'h00C, 10'h010, 10'h100,
                              10'h104, 10'h108, 10'h10C, 10'h110, 10'h200, 10'h3F0};

    function automatic logic [9:0] pick_addr();
        return atab[$urandom_range(0, 11)] | 10'($urandom_range(0, 3));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  rs;
        bit          hs;
        #2 aresetn = 0;
        #1 cmp_en = 1;
        repeat (2) @(negedge aclk);
        chk("rst_pl_to_ps_ready", 32'(pl_to_ps_ready_o), 32'd1);
        chk("rst_ps_to_pl_v", 32'(ps_to_pl_v_o), 32'd0);
        chk("rst_arready", 32'(s00_axi_arready), 32'd0);
        @(posedge aclk); #1 aresetn = 1;

        rd(10'h004, d, rs); chk("free_after_rst", d, 32'd16); chk("free_resp", 32'(rs), 32'd0);
        rd(10'h00C, d, rs); chk("occ_after_rst", d, 32'd0);

        wr(10'h000, 32'hA5A5_0001, 4'hF, rs);
        chk("push_resp", 32'(rs), 32'd0);
        chk("push_visible_v", 32'(ps_to_pl_v_o), 32'd1);
        chk("push_visible_data", ps_to_pl_data_o, 32'hA5A5_0001);
        for (int i = 0; i < 16; i++) begin
            wr(10'h000, 32'h0000_0100 + 32'(i), 4'hF, rs);
            chk("fill_resp", 32'(rs), (i == 15) ? 32'd2 : 32'd0);
        end
        rd(10'h010, d, rs); chk("status_ovf", d, 32'h1);
        rd(10'h004, d, rs); chk("free_when_full", d, 32'd0);

        pl_to_ps_v_i = 1; pl_to_ps_data_i = 32'h1234_5678;
        @(posedge aclk); #1 pl_to_ps_data_i = 32'h9ABC_DEF0;
        @(posedge aclk); #1 pl_to_ps_v_i = 0;
        rd(10'h00C, d, rs); chk("occ_two", d, 32'd2);
        rd(10'h008, d, rs); chk("pop1_data", d, 32'h1234_5678); chk("pop1_resp", 32'(rs), 32'd0);
        rd(10'h008, d, rs); chk("pop2_data", d, 32'h9ABC_DEF0); chk("pop2_resp", 32'(rs), 32'd0);
        rd(10'h008, d, rs); chk("pop3_data", d, 32'h0); chk("pop3_resp", 32'(rs), 32'd2);
        rd(10'h010, d, rs); chk("status_both", d, 32'h3);
        wr(10'h010, 32'h3, 4'hF, rs);
        rd(10'h010, d, rs); chk("status_cleared", d, 32'h0);

        wr(10'h108, 32'hFFFF_FFFF, 4'b0101, rs);
        chk("csr2_strb", csr_o[95:64], 32'h00FF_00FF);
        rd(10'h108, d, rs); chk("csr2_readback", d, 32'h00FF_00FF);

        s00_axi_awaddr = 10'h104; s00_axi_wdata = 32'h11; s00_axi_wstrb = 4'hF;
        s00_axi_awvalid = 1; s00_axi_wvalid = 1; s00_axi_bready = 0;
        hs = 0;
        for (int i = 0; i < 32 && !hs; i++) begin
            @(negedge aclk); hs = s00_axi_awready;
            @(posedge aclk); #1;
        end
        chk("bp_first_hs", 32'(hs), 32'd1);
        s00_axi_awaddr = 10'h10C; s00_axi_wdata = 32'h22;
        s00_axi_araddr = 10'h104; s00_axi_arvalid = 1; s00_axi_rready = 1;
        @(negedge aclk);
        chk("bp_bvalid_hold", 32'(s00_axi_bvalid), 32'd1);
        chk("bp_awready_blocked", 32'(s00_axi_awready), 32'd0);
        chk("bp_arready", 32'(s00_axi_arready), 32'd1);
        @(posedge aclk); #1 s00_axi_arvalid = 0;
        @(negedge aclk);
        chk("bp_read_rvalid", 32'(s00_axi_rvalid), 32'd1);
        chk("bp_read_data", s00_axi_rdata, 32'h11);
        chk("bp_awready_still0", 32'(s00_axi_awready), 32'd0);
        @(posedge aclk); #1 s00_axi_rready = 0; s00_axi_bready = 1;
        @(negedge aclk); chk("bp_awready_during_b", 32'(s00_axi_awready), 32'd0);
        @(posedge aclk); #1 s00_axi_bready = 0;
        @(negedge aclk); chk("bp_second_awready", 32'(s00_axi_awready), 32'd1);
        @(posedge aclk); #1 s00_axi_awvalid = 0; s00_axi_wvalid = 0; s00_axi_bready = 1;
        @(negedge aclk); chk("bp_second_bvalid", 32'(s00_axi_bvalid), 32'd1);
        @(posedge aclk); #1 s00_axi_bready = 0;
        chk("bp_csr3", csr_o[127:96], 32'h22);

        ps_to_pl_ready_i = 1;
        repeat (20) @(posedge aclk);
        #1 ps_to_pl_ready_i = 0;
        rd(10'h004, d, rs); chk("free_after_drain", d, 32'd16);

`ifdef ZYNQ_AXIL_FIFO_BRIDGE_LOOPBACK_EN
        wr(10'h010, 32'h100, 4'hF, rs);
        wr(10'h000, 32'hCAFE_0000, 4'hF, rs);
        repeat (3) @(posedge aclk);
        #1;
        rd(10'h008, d, rs); chk("lb_data", d, 32'hCAFE_0000); chk("lb_resp", 32'(rs), 32'd0);
        rd(10'h010, d, rs); chk("lb_status", d, 32'h100);
        wr(10'h010, 32'h0, 4'hF, rs);
`endif

        for (int c = 0; c < 4000; c++) begin
            if (c == 2000) aresetn = 0;
            if (c == 2003) aresetn = 1;
            s00_axi_awvalid  = ($urandom_range(0, 2) == 0);
            s00_axi_wvalid   = ($urandom_range(0, 3) != 0);
            s00_axi_awaddr   = pick_addr();
            s00_axi_wdata    = $urandom;
            s00_axi_wstrb    = 4'($urandom_range(0, 15));
            s00_axi_bready   = ($urandom_range(0, 1) == 1);
            s00_axi_arvalid  = ($urandom_range(0, 2) == 0);
            s00_axi_araddr   = pick_addr();
            s00_axi_rready   = ($urandom_range(0, 1) == 1);
            s00_axi_awprot   = 3'($urandom_range(0, 7));
            s00_axi_arprot   = 3'($urandom_range(0, 7));
            ps_to_pl_ready_i = ($urandom_range(0, 2) == 0);
            pl_to_ps_v_i     = ($urandom_range(0, 1) == 1);
            pl_to_ps_data_i  = $urandom;
            @(posedge aclk); #1;
        end
        s00_axi_awvalid = 0; s00_axi_wvalid = 0; s00_axi_arvalid = 0;
        s00_axi_bready = 1; s00_axi_rready = 1; pl_to_ps_v_i = 0; ps_to_pl_ready_i = 0;
        repeat (4) @(posedge aclk);
        #1 cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
